// File: rtl/mtimer_if.sv
// rtl/mtimer_if.sv - req/gnt bus bundle shared by the memory-mapped slaves
interface mtimer_if;
  logic        ce_i;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [1:0]  hb_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (
    output ce_i, req_i, we_i, hb_i, addr_i, wdata_i,
    input  gnt_o, rdata_o
  );

  modport slave (
    input  ce_i, req_i, we_i, hb_i, addr_i, wdata_i,
    output gnt_o, rdata_o
  );
endinterface

// File: rtl/mtimer.sv
// rtl/mtimer.sv - RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler and level irq
module mtimer #(
  parameter int PRESCALE_W = 16,
  parameter int ADDR_W     = 5
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mtimer_if.slave  bus,
  output logic     irq_o
);

  localparam logic [2:0] SEL_MTIME_LO = 3'd0;
  localparam logic [2:0] SEL_MTIME_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO   = 3'd2;
  localparam logic [2:0] SEL_CMP_HI   = 3'd3;
  localparam logic [2:0] SEL_CTRL     = 3'd4;
  localparam logic [2:0] SEL_PRESCALE = 3'd5;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  en;
  logic                  ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           hi_shadow;

  logic [ADDR_W-1:0]     a_low;
  logic [2:0]            sel;
  logic [1:0]            lane;
  logic                  accept;
  logic                  wr;
  logic                  rd;
  logic                  tick;
  logic [31:0]           live_word;
  logic [31:0]           read_word;
  logic [31:0]           wr_word;
  logic                  unused_bits;

  assign a_low  = bus.addr_i[ADDR_W-1:0];
  assign sel    = a_low[4:2];
  assign lane   = a_low[1:0];
  assign accept = bus.ce_i & bus.req_i & ~bus.gnt_o;
  assign wr     = accept & bus.we_i;
  assign rd     = accept & ~bus.we_i;
  assign tick   = en & (pcnt == prescale);

  assign unused_bits = &{1'b0, bus.addr_i[31:ADDR_W], wr_word[31:PRESCALE_W]};

  // live_word is the merge base for writes; reads of MTIME_HI see the shadow instead
  always_comb begin
    live_word = 32'd0;
    case (sel)
      SEL_MTIME_LO: live_word = mtime[31:0];
      SEL_MTIME_HI: live_word = mtime[63:32];
      SEL_CMP_LO:   live_word = mtimecmp[31:0];
      SEL_CMP_HI:   live_word = mtimecmp[63:32];
      SEL_CTRL:     live_word = {30'd0, ie, en};
      SEL_PRESCALE: live_word = {{(32-PRESCALE_W){1'b0}}, prescale};
      default:      live_word = 32'd0;
    endcase
    read_word = (sel == SEL_MTIME_HI) ? hi_shadow : live_word;
  end

  always_comb begin
    wr_word = live_word;
    case (bus.hb_i)
      2'b00: begin
        case (lane)
          2'd0:    wr_word[7:0]   = bus.wdata_i[7:0];
          2'd1:    wr_word[15:8]  = bus.wdata_i[7:0];
          2'd2:    wr_word[23:16] = bus.wdata_i[7:0];
          default: wr_word[31:24] = bus.wdata_i[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) wr_word[31:16] = bus.wdata_i[15:0];
        else         wr_word[15:0]  = bus.wdata_i[15:0];
      end
      default: wr_word = bus.wdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime       <= 64'd0;
      mtimecmp    <= {64{1'b1}};
      en          <= 1'b0;
      ie          <= 1'b0;
      prescale    <= '0;
      pcnt        <= '0;
      hi_shadow   <= 32'd0;
      bus.gnt_o   <= 1'b0;
      bus.rdata_o <= 32'd0;
      irq_o       <= 1'b0;
    end else begin
      // a software write to either mtime word swallows a coincident tick
      if (wr && sel == SEL_MTIME_LO)      mtime[31:0]  <= wr_word;
      else if (wr && sel == SEL_MTIME_HI) mtime[63:32] <= wr_word;
      else if (tick)                      mtime        <= mtime + 64'd1;

      if (wr && sel == SEL_CMP_LO) mtimecmp[31:0]  <= wr_word;
      if (wr && sel == SEL_CMP_HI) mtimecmp[63:32] <= wr_word;
      if (wr && sel == SEL_CTRL)   {ie, en}        <= wr_word[1:0];

      if (wr && sel == SEL_PRESCALE) begin
        prescale <= wr_word[PRESCALE_W-1:0];
        pcnt     <= '0;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
      end

      bus.gnt_o <= accept;
      if (rd) begin
        bus.rdata_o <= read_word;
        if (sel == SEL_MTIME_LO) hi_shadow <= mtime[63:32];
      end

      irq_o <= ie & (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// tb/tb_mtimer.sv - directed and randomized checks of mtimer against a behavioural model
module tb_mtimer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  mtimer_if bus ();

  mtimer #(.PRESCALE_W(16), .ADDR_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // model state: registers as the programmer sees them, prescaler as enabled-cycle count
  logic [63:0]     m_mtime;
  logic [63:0]     m_cmp;
  logic            m_en;
  logic            m_ie;
  logic [15:0]     m_pre;
  longint unsigned m_div;
  logic [31:0]     m_shadow;
  logic [31:0]     m_rdata;
  logic            m_gnt;
  logic            m_irq;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s:%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mtime  = 64'd0;
    m_cmp    = {64{1'b1}};
    m_en     = 1'b0;
    m_ie     = 1'b0;
    m_pre    = 16'd0;
    m_div    = 0;
    m_shadow = 32'd0;
    m_rdata  = 32'd0;
    m_gnt    = 1'b0;
    m_irq    = 1'b0;
  endtask

  function automatic logic [31:0] live_value(logic [2:0] s);
    case (s)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {30'd0, m_ie, m_en};
      3'd5:    return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d,
                                        logic [1:0] hb, logic [1:0] a);
    logic [31:0] mask;
    logic [31:0] ins;
    int          s;
    if (hb[1]) return d;
    if (hb == 2'b01) begin
      s    = a[1] ? 16 : 0;
      mask = 32'h0000_FFFF << s;
      ins  = (d & 32'h0000_FFFF) << s;
    end else begin
      s    = 8 * int'(a);
      mask = 32'h0000_00FF << s;
      ins  = (d & 32'h0000_00FF) << s;
    end
    return (old & ~mask) | ins;
  endfunction

  task automatic drive_idle();
    bus.ce_i    = 1'b0;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.hb_i    = 2'b10;
    bus.addr_i  = 32'd0;
    bus.wdata_i = 32'd0;
  endtask

  // one clock edge: advance the model with the inputs present at that edge, then compare
  task automatic cyc();
    logic            acc;
    logic            tick;
    logic            n_irq;
    logic [2:0]      s;
    logic [31:0]     mw;
    logic [63:0]     n_mtime;
    longint unsigned period;
    @(posedge clk);
    acc     = bus.ce_i && bus.req_i && !m_gnt;
    s       = bus.addr_i[4:2];
    period  = longint'(m_pre) + 1;
    tick    = m_en && ((m_div % period) == (period - 1));
    n_irq   = m_ie && (m_mtime >= m_cmp);
    n_mtime = m_mtime + (tick ? 64'd1 : 64'd0);
    if (m_en) m_div++;
    if (acc && !bus.we_i) begin
      m_rdata = (s == 3'd1) ? m_shadow : live_value(s);
      if (s == 3'd0) m_shadow = m_mtime[63:32];
    end
    if (acc && bus.we_i) begin
      mw = merge(live_value(s), bus.wdata_i, bus.hb_i, bus.addr_i[1:0]);
      case (s)
        3'd0: n_mtime = {m_mtime[63:32], mw};
        3'd1: n_mtime = {mw, m_mtime[31:0]};
        3'd2: m_cmp[31:0]  = mw;
        3'd3: m_cmp[63:32] = mw;
        3'd4: begin m_en = mw[0]; m_ie = mw[1]; end
        3'd5: begin m_pre = mw[15:0]; m_div = 0; end
        default: ;
      endcase
    end
    m_mtime = n_mtime;
    m_gnt   = acc;
    m_irq   = n_irq;
    #1;
    check("gnt", bus.gnt_o, m_gnt);
    check("rdata", bus.rdata_o, m_rdata);
    check("irq", irq, m_irq);
  endtask

  task automatic access(bit w, logic [1:0] hb, logic [31:0] a, logic [31:0] d);
    bus.ce_i    = 1'b1;
    bus.req_i   = 1'b1;
    bus.we_i    = w;
    bus.hb_i    = hb;
    bus.addr_i  = a;
    bus.wdata_i = d;
    cyc();
    drive_idle();
    cyc();
  endtask

  task automatic wr32(logic [31:0] a, logic [31:0] d);
    access(1'b1, 2'b10, a, d);
  endtask

  task automatic rd32(logic [31:0] a);
    access(1'b0, 2'b10, a, 32'd0);
  endtask

  logic [31:0] reset_tab [7];
  logic [31:0] v;
  logic [31:0] first_val;

  initial begin
    reset_tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    drive_idle();
    m_reset();

    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("gnt", bus.gnt_o, 1'b0);
    check("rdata", bus.rdata_o, 32'd0);
    check("irq", irq, 1'b0);
    rst = 1'b0;
    for (int r = 0; r < 7; r++) begin
      rd32(32'(r * 4));
      check("reset_read", bus.rdata_o, reset_tab[r]);
    end

    phase = "prescale";
    wr32(32'h14, 32'd3);
    wr32(32'h10, 32'd1);
    repeat (40) cyc();
    rd32(32'h00);
    v = bus.rdata_o;
    check("rate_10pm1", (v >= 32'd9 && v <= 32'd11), 1'b1);
    wr32(32'h10, 32'd0);
    rd32(32'h00);
    first_val = bus.rdata_o;
    repeat (20) cyc();
    rd32(32'h00);
    check("frozen", bus.rdata_o, first_val);

    phase = "wrap";
    wr32(32'h00, 32'hFFFF_FFFE);
    wr32(32'h04, 32'hFFFF_FFFF);
    wr32(32'h14, 32'd0);
    wr32(32'h10, 32'd1);
    repeat (2) cyc();
    rd32(32'h00);
    check("lo_after_wrap", bus.rdata_o, 32'h0000_0001);
    rd32(32'h04);
    check("hi_after_wrap", bus.rdata_o, 32'h0000_0000);

    phase = "latch";
    wr32(32'h10, 32'd0);
    wr32(32'h00, 32'hFFFF_FFFF);
    wr32(32'h04, 32'hFFFF_FFFF);
    wr32(32'h14, 32'd3);
    wr32(32'h10, 32'd1);
    rd32(32'h00);
    check("lo_at_max", bus.rdata_o, 32'hFFFF_FFFF);
    rd32(32'h04);
    check("hi_latched", bus.rdata_o, 32'hFFFF_FFFF);
    rd32(32'h00);

    phase = "irq";
    wr32(32'h10, 32'd0);
    wr32(32'h0C, 32'd0);
    wr32(32'h08, 32'd20);
    wr32(32'h00, 32'd0);
    wr32(32'h04, 32'd0);
    wr32(32'h14, 32'd0);
    wr32(32'h10, 32'd3);
    repeat (30) cyc();
    check("irq_on", irq, 1'b1);
    wr32(32'h08, 32'hFFFF_FFFF);
    check("irq_off_cmp", irq, 1'b0);
    wr32(32'h08, 32'd5);
    repeat (2) cyc();
    check("irq_on_again", irq, 1'b1);
    wr32(32'h10, 32'd1);
    repeat (3) cyc();
    check("irq_off_ie", irq, 1'b0);

    phase = "merge";
    wr32(32'h10, 32'd0);
    wr32(32'h14, 32'h0000_1234);
    access(1'b1, 2'b00, 32'h15, 32'h0000_00AB);
    rd32(32'h14);
    check("byte_lane1", bus.rdata_o, 32'h0000_AB34);
    wr32(32'h08, 32'h0000_1234);
    access(1'b1, 2'b01, 32'h0B, 32'h0000_5555);
    rd32(32'h08);
    check("half_lane1", bus.rdata_o, 32'h5555_1234);
    access(1'b1, 2'b11, 32'h0E, 32'hCAFE_F00D);
    rd32(32'h0C);
    check("hb11_word", bus.rdata_o, 32'hCAFE_F00D);

    phase = "random";
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(31, 0));
      access(1'b1, 2'($urandom_range(3, 0)), ra, $urandom);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(5, 1)) cyc();
      rd32({ra[31:2], 2'b00});
    end

    phase = "b2b";
    wr32(32'h10, 32'd0);
    bus.ce_i   = 1'b1;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h00;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("gnt_pattern", bus.gnt_o, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    cyc();
    check("gnt_pending", bus.gnt_o, 1'b1);

    phase = "midreset";
    rst = 1'b1;
    #1;
    check("gnt_dropped", bus.gnt_o, 1'b0);
    check("rdata_cleared", bus.rdata_o, 32'd0);
    check("irq_cleared", irq, 1'b0);
    m_reset();
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd32(32'h00);
    check("mtime_reset", bus.rdata_o, 32'd0);
    rd32(32'h08);
    check("cmp_reset", bus.rdata_o, 32'hFFFF_FFFF);
    rd32(32'h10);
    check("ctrl_reset", bus.rdata_o, 32'd0);

    phase = "unmapped";
    wr32(32'h18, 32'h1234_5678);
    rd32(32'h18);
    check("off18_read", bus.rdata_o, 32'd0);
    wr32(32'h1C, 32'hDEAD_BEEF);
    rd32(32'h1C);
    check("off1c_read", bus.rdata_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped RISC-V machine timer peripheral on chip-select BUS_CE[3].
- Uses the same req/gnt bus handshake as the other bus slaves (ram, uart).
- Holds a 64-bit mtime counter advanced by a programmable prescaler, plus a 64-bit mtimecmp compare register.
- irq_o drives the core's i_MEI_1 external interrupt line.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and counter.
- ADDR_W, 5, number of low address bits decoded (bits [4:2] select the register).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous reset, active-high.
- ce_i  input  1  chip enable (BUS_CE[3]).
- req_i  input  1  bus request.
- gnt_o  output  1  bus grant / access complete.
- we_i  input  1  write strobe (1=write, 0=read).
- hb_i  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- addr_i  input  32  byte address; only [ADDR_W-1:0] decoded.
- wdata_i  input  32  write data, right-aligned (byte/half in low bits).
- rdata_o  output  32  read data, valid while gnt_o=1.
- irq_o  output  1  timer interrupt, level.

Behaviour:
- Reset: the following are cleared asynchronously on rst_i=1:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - CTRL=0, PRESCALE=0, prescaler counter=0, hi shadow=0.
  - gnt_o=0, rdata_o=0, irq_o=0.
- Register map (addr_i[4:2]):
  - 0 MTIME_LO.
  - 1 MTIME_HI.
  - 2 MTIMECMP_LO.
  - 3 MTIMECMP_HI.
  - 4 CTRL: bit0 EN, bit1 IE; other bits read 0.
  - 5 PRESCALE.
  - 6-7 unmapped: read 0, writes ignored, still granted.
- Handshake:
  - An access is accepted on a rising edge where ce_i & req_i & ~gnt_o.
  - gnt_o=1 on the following cycle for exactly one cycle; rdata_o is registered and valid in that cycle.
  - If req_i is held high, accepts occur every other cycle.
  - gnt_o=0 whenever no access was accepted on the previous edge.
  - rdata_o holds its last value when gnt_o=0.
- Write merging:
  - hb_i=10/11: full 32-bit write; addr_i[1:0] ignored.
  - hb_i=01: wdata_i[15:0] goes to halfword lane addr_i[1] (bit0 ignored); the other lane is kept.
  - hb_i=00: wdata_i[7:0] goes to byte lane addr_i[1:0]; the other bytes are kept.
- Reads always return the full 32-bit register regardless of hb_i.
- Atomic 64-bit read:
  - Reading MTIME_LO returns mtime[31:0] and, on the same edge, latches mtime[63:32] into the hi shadow.
  - Reading MTIME_HI returns the shadow, not the live value.
  - Writes to MTIME_HI update live mtime only, not the shadow.
- Prescaler and counting:
  - While EN=1, the counter increments each cycle.
  - When counter==PRESCALE, the counter resets to 0 and mtime increments by 1 (so PRESCALE=0 gives one tick per cycle).
  - mtime wraps 2^64-1 -> 0.
  - EN=0 freezes both mtime and the counter.
  - Writing PRESCALE clears the counter.
- Simultaneous events:
  - A bus write to MTIME_LO/HI on the same edge as a tick wins; the tick is dropped, and only the written word changes.
  - A write to CTRL takes effect from the next edge.
- Interrupt:
  - irq_o is registered: irq_o <= IE & (mtime >= mtimecmp), unsigned 64-bit compare using the current register values.
  - Latency is 1 cycle after the compare becomes true.
  - irq_o deasserts 1 cycle after mtimecmp is raised above mtime or IE is cleared.
  - There is no sticky flag.
- Reset mid-operation:
  - An in-flight grant is dropped (gnt_o=0).
  - All registers return to reset values.

Test Plan:
- Reset, then a read of each register.
  - Expect 0, 0, FFFF_FFFF, FFFF_FFFF, 0, 0, 0.
  - gnt_o high exactly 1 cycle after each accept; irq_o=0.
- PRESCALE=3, CTRL=1, wait 40 cycles.
  - mtime advances by 1 every 4 cycles (10 ±1).
  - EN=0 then freezes the value over 20 cycles.
- MTIME_LO=FFFF_FFFE, MTIME_HI=FFFF_FFFF, PRESCALE=0, EN=1.
  - After 3 ticks: read LO=0000_0001, HI=0000_0000 (wrap).
  - A read of LO at FFFF_FFFF followed by a carry still returns the latched HI=FFFF_FFFF.
- MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3, mtime=0.
  - irq_o rises exactly 1 cycle after mtime reaches 20.
  - Writing MTIMECMP_LO=FFFF_FFFF drops irq_o 1 cycle later.
  - CTRL=1 with mtime>=cmp keeps irq_o=0.
- Byte write 8'hAB to PRESCALE offset+1 (hb_i=00, addr[1:0]=01) over 0000_1234: read returns 0000_AB34.
  - Halfword write 16'h5555 with addr[1]=1 over 0000_1234: read returns 5555_1234.
- Held req_i/ce_i with back-to-back reads: gnt_o pattern 0101...
  - Assert rst_i while gnt_o is pending: gnt_o=0 immediately and registers reset.
  - Access to offset 0x18 reads 0 and is granted.
